// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit: FSM state
// encodings and operation codes. The optional divider is controlled by the
// MULDIV_DIV_EN macro in the files that import this package.
package muldiv_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide unit.
// Multiply: acc <- (acc << 1) + (bit_in ? opnd : 0), multiplier bits MSB first.
// Divide (only with MULDIV_DIV_EN): restoring step on the remainder held in
// acc[WIDTH-1:0]; bit_in is the next dividend bit, q_bit the quotient bit.
module muldiv_step
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic               op,
  input  logic               bit_in,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [2*WIDTH-1:0] mul_acc;
  logic               unused_msb;

  // The product MSB is shifted out before it could ever be set.
  assign unused_msb = acc[2*WIDTH-1];

  // Shift-add: the single adder shared by every multiply step.
  always_comb begin
    mul_acc = {acc[2*WIDTH-2:0], 1'b0} + (bit_in ? {{WIDTH{1'b0}}, opnd} : {2*WIDTH{1'b0}});
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] diff;
  logic             unused_diff;

  // A successful subtract leaves a remainder below the divisor, so bit WIDTH is always 0.
  assign unused_diff = diff[WIDTH];

  // Restoring subtract; with a zero divisor every step succeeds, which
  // naturally yields an all-ones quotient and a remainder equal to the dividend.
  always_comb begin
    rem_shift = {acc[WIDTH-1:0], bit_in};
    diff      = {1'b0, rem_shift} - {2'b00, opnd};
    acc_next  = mul_acc;
    q_bit     = 1'b0;
    if (op == OP_DIV) begin
      q_bit    = ~diff[WIDTH+1];
      acc_next = {{WIDTH{1'b0}}, (q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0])};
    end
  end
`else
  logic unused_op;

  assign unused_op = op;

  // Multiply-only build: no subtractor, quotient bit is constant.
  always_comb begin
    acc_next = mul_acc;
    q_bit    = 1'b0;
  end
`endif

endmodule

// File: rtl/muldiv_seq.sv
// Sequential unsigned multiply/divide unit, one step per clock.
// Define MULDIV_DIV_EN to build the divider; without it op is ignored and
// every operation is a multiply with identical timing.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             zero,
  output logic             dz
);

  localparam int                 COUNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [COUNT_W-1:0] LAST    = COUNT_W'(WIDTH - 1);

  state_t               state, state_next;
  logic [COUNT_W-1:0]   count;
  logic [2*WIDTH-1:0]   acc, acc_next;
  logic [WIDTH-1:0]     sh, opnd;
  logic [WIDTH-1:0]     fin_lo, fin_hi;
  logic                 op_r, op_eff, q_bit, accept, last_step;

`ifdef MULDIV_DIV_EN
  logic dz_r;

  assign op_eff = op;
  assign dz     = dz_r;
`else
  logic unused_op;

  assign unused_op = op;
  assign op_eff    = OP_MUL;
  assign dz        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state and handshake outputs; start is only looked at in IDLE and DONE.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    last_step  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (count == LAST) begin
          last_step  = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Step counter: cleared on accept, advances once per RUN cycle.
  always_ff @(posedge clk) begin
    if (reset)       count <= '0;
    else if (accept) count <= '0;
    else if (busy)   count <= count + COUNT_W'(1);
  end

  // Operand capture and iteration. sh streams the multiplier (or dividend)
  // MSB first and, for divide, collects quotient bits at the LSB.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r <= op_eff;
      acc  <= '0;
      sh   <= (op_eff == OP_DIV) ? a : b;
      opnd <= (op_eff == OP_DIV) ? b : a;
    end else if (busy) begin
      acc <= acc_next;
      sh  <= {sh[WIDTH-2:0], q_bit};
    end
  end

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc      (acc),
    .op       (op_r),
    .bit_in   (sh[WIDTH-1]),
    .opnd     (opnd),
    .acc_next (acc_next),
    .q_bit    (q_bit)
  );

  // Result of the final step, before it is registered.
  always_comb begin
    if (op_r == OP_DIV) begin
      fin_lo = {sh[WIDTH-2:0], q_bit};
      fin_hi = acc_next[WIDTH-1:0];
    end else begin
      fin_lo = acc_next[WIDTH-1:0];
      fin_hi = acc_next[2*WIDTH-1:WIDTH];
    end
  end

  // Result registers: loaded on the last step, held until the next result or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_lo <= '0;
      res_hi <= '0;
      zero   <= 1'b0;
    end else if (last_step) begin
      res_lo <= fin_lo;
      res_hi <= fin_hi;
      zero   <= (fin_lo == '0);
    end
  end

`ifdef MULDIV_DIV_EN
  // Divide-by-zero flag, registered alongside the result.
  always_ff @(posedge clk) begin
    if (reset)          dz_r <= 1'b0;
    else if (last_step) dz_r <= (op_r == OP_DIV) && (opnd == '0);
  end
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq (WIDTH = 8). Expected results come from plain
// arithmetic; MULDIV_DIV_EN selects whether op = 1 means divide.
module tb_muldiv_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset, start, op;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, zero, dz;
  logic [WIDTH-1:0] res_lo, res_hi;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .res_lo (res_lo),
    .res_hi (res_hi),
    .zero   (zero),
    .dz     (dz)
  );

  // Reference: returns {dz, hi, lo}.
  function automatic logic [16:0] model(input logic [7:0] x, input logic [7:0] y, input logic o);
    int   p;
    logic do_div;
`ifdef MULDIV_DIV_EN
    do_div = o;
`else
    do_div = o & 1'b0;
`endif
    if (do_div) begin
      if (y == 8'd0) return {1'b1, x, 8'hFF};
      return {1'b0, 8'(x % y), 8'(x / y)};
    end
    p = x * y;
    return {1'b0, 16'(p)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands with start and let the start edge pass; then scramble inputs.
  task automatic launch(input logic [7:0] x, input logic [7:0] y, input logic o, input logic hold);
    start = 1'b1; a = x; b = y; op = o;
    @(posedge clk); #1;
    start = hold;
    a = 8'($urandom); b = 8'($urandom); op = 1'($urandom);
  endtask

  // Count edges until done (start edge is edge 1), then check the result.
  task automatic wait_done(input string tag, input logic [7:0] x, input logic [7:0] y,
                           input logic o, input logic hold);
    int          edges;
    logic [16:0] e;
    e     = model(x, y, o);
    edges = 1;
    chk({tag, "/busy"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && edges < 20) begin
      if (hold) begin
        a = 8'($urandom); b = 8'($urandom);
        if (edges == 8) start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, "/latency"}, 32'(edges), 32'd9);
    chk({tag, "/res_lo"}, 32'(res_lo), 32'(e[7:0]));
    chk({tag, "/res_hi"}, 32'(res_hi), 32'(e[15:8]));
    chk({tag, "/zero"}, 32'(zero), 32'(e[7:0] == 8'd0));
    chk({tag, "/dz"}, 32'(dz), 32'(e[16]));
  endtask

  initial begin
    logic [7:0] x, y;
    logic       o;
    int         extra_done;

    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/done", 32'(done), 32'd0);
    chk("rst/res_lo", 32'(res_lo), 32'd0);
    chk("rst/res_hi", 32'(res_hi), 32'd0);
    chk("rst/zero", 32'(zero), 32'd0);
    chk("rst/dz", 32'(dz), 32'd0);
    reset = 1'b0;

    // 13 * 11 = 143
    @(negedge clk); launch(8'd13, 8'd11, 1'b0, 1'b0);
    wait_done("mul13x11", 8'd13, 8'd11, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("hold/done", 32'(done), 32'd0);
    chk("hold/busy", 32'(busy), 32'd0);
    chk("hold/res_lo", 32'(res_lo), 32'h8F);

    // 255 * 255 with start held through RUN
    @(negedge clk); launch(8'd255, 8'd255, 1'b0, 1'b1);
    wait_done("mul255x255", 8'd255, 8'd255, 1'b0, 1'b1);
    extra_done = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra_done++;
    end
    chk("one_pulse", 32'(extra_done), 32'd0);

    // 0 * 77, then a start in the DONE cycle
    @(negedge clk); launch(8'd0, 8'd77, 1'b0, 1'b0);
    wait_done("mul0x77", 8'd0, 8'd77, 1'b0, 1'b0);
    launch(8'd3, 8'd5, 1'b0, 1'b0);
    chk("b2b/busy", 32'(busy), 32'd1);
    chk("b2b/done", 32'(done), 32'd0);
    wait_done("mul3x5", 8'd3, 8'd5, 1'b0, 1'b0);

    // 200 / 7 then back-to-back 0x5A / 0
    @(negedge clk); launch(8'd200, 8'd7, 1'b1, 1'b0);
    wait_done("op1_200_7", 8'd200, 8'd7, 1'b1, 1'b0);
    launch(8'h5A, 8'd0, 1'b1, 1'b0);
    wait_done("op1_5A_0", 8'h5A, 8'd0, 1'b1, 1'b0);

    // Reset at step 4 of a multiply
    @(negedge clk); launch(8'd100, 8'd50, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    chk("abort/busy", 32'(busy), 32'd0);
    chk("abort/done", 32'(done), 32'd0);
    chk("abort/res", 32'({res_hi, res_lo}), 32'd0);
    chk("abort/flags", 32'({zero, dz}), 32'd0);
    reset = 1'b0;
    extra_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra_done++;
    end
    chk("abort/no_done", 32'(extra_done), 32'd0);
    @(negedge clk); launch(8'd3, 8'd3, 1'b0, 1'b0);
    wait_done("mul3x3", 8'd3, 8'd3, 1'b0, 1'b0);

    // Randomized operations against the reference
    for (int i = 0; i < 40; i++) begin
      x = 8'($urandom);
      y = (i % 8 == 0) ? 8'd0 : 8'($urandom);
      o = 1'($urandom);
      @(negedge clk); launch(x, y, o, 1'b0);
      wait_done($sformatf("rand%0d", i), x, y, o, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
